arbiter_seq_gen: RTL and testbench
==================================

# arbiter_seq_gen

Parametrised channel-request sequencer that drives the arbiter's channel-select input from a preloaded list of virtual-channel IDs. It sits in the arbiter test and traffic path, between a flat bus of `NUM_CH`-ary channel IDs and the arbiter's select port. It generalises the fixed 4-channel, 64-entry interface:
- configurable channel count and depth;
- programmable sequence length;
- valid/ready handshake toward the arbiter;
- optional looping and per-channel issue statistics.

## Interface
- `NUM_CH`, 4, number of virtual channels; must be at least 2.
- `DEPTH`, 64, maximum number of sequence entries.
- `CH_W`, `$clog2(NUM_CH)`, width of one channel ID (derived, not overridden).
- `LEN_W`, `$clog2(DEPTH+1)`, width of the length field (derived).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enb`  in  1  global enable; when low, all state is frozen.
- `init`  in  1  start/restart pulse; sampled only when `enb`=1.
- `tester_input`  in  `DEPTH*CH_W`  entry k occupies bits `[k*CH_W +: CH_W]`; entry 0 is issued first.
- `seq_len`  in  `LEN_W`  number of entries to issue; values above `DEPTH` saturate to `DEPTH`.
- `loop`  in  1  1 = wrap to entry 0 after the last entry; latched at `init`.
- `arb_ready`  in  1  arbiter accepts the current ID.
- `arbiter_input`  out  `CH_W`  current channel ID (registered).
- `arbiter_valid`  out  1  `arbiter_input` is valid (registered).
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse when a non-looping sequence completes.
- `hist_count`  out  `NUM_CH*16`  per-channel accepted-ID counters (see Configuration).

## Operation
- States:
  - IDLE: wait for `init`.
  - RUN: issue entries.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- On `init` (with `enb`=1) in IDLE, RUN or DONE:
  - latch `tester_input` into an internal shadow array;
  - latch `min(seq_len, DEPTH)` and `loop`;
  - set index to 0.
  - If the latched length is 0, go to DONE. Otherwise go to RUN and present entry 0.
- `init` in RUN is a restart. The in-flight ID is dropped and the new sequence starts at entry 0.
- In RUN, a transfer happens when `arbiter_valid && arb_ready`. On a transfer:
  - if index is below len-1: index increments and `arbiter_input` is set to entry[index+1];
  - if index equals len-1 and `loop`=1: index returns to 0, entry 0 is presented, state stays RUN;
  - if index equals len-1 and `loop`=0: `arbiter_valid` drops and state goes to DONE.
- With `arb_ready`=0, `arbiter_input` and `arbiter_valid` hold stable. The ID must never change while valid is high and not yet accepted.
- Changes on `tester_input`, `seq_len` or `loop` after `init` have no effect until the next `init`.
- `enb`=0 holds every register, including outputs, and ignores `init`. A transfer can still complete if `arb_ready` is sampled while `enb`=0; it is not counted, and the index does not advance.

## Timing
- Reset values: `arbiter_input`=0, `arbiter_valid`=0, `busy`=0, `done`=0, `hist_count`=0, state IDLE, index 0.
- Reset has priority over `init` and `enb`. Reset mid-RUN returns to IDLE on the next edge.
- Latency: when `init` is sampled at edge N, `arbiter_valid`=1 and `arbiter_input`=entry 0 from edge N+1.
- Throughput is one ID per cycle while `arb_ready`=1.
- `done` is high exactly one cycle: the cycle after the final transfer.
- `busy` equals (state == RUN).

## Configuration
- `ARB_SEQ_HISTOGRAM_EN` defined:
  - each accepted transfer with `enb`=1 increments a 16-bit counter for channel `arbiter_input`;
  - counters saturate at 0xFFFF;
  - counters are cleared by `rst` and by `init`;
  - counter c is driven on `hist_count[c*16 +: 16]`.
- `ARB_SEQ_HISTOGRAM_EN` not defined: no counters are built and `hist_count` is tied to 0.

## Structure
- Package `arb_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the 16-bit histogram width constant;
  - an entry-extract helper function.
- Sub-module `arb_seq_hist` holds the saturating per-channel counters. It is instantiated only under `ARB_SEQ_HISTOGRAM_EN`.

## Test plan
- Reset and idle:
  - stimulus: `rst`=1 for 2 cycles, then `enb`=1 with no `init` for 10 cycles;
  - response: all outputs 0, state IDLE.
- Basic run:
  - stimulus: entries {2,0,1,2,1}, `seq_len`=5, `loop`=0, `arb_ready`=1, `init` pulse;
  - response: IDs 2,0,1,2,1 on 5 consecutive cycles starting the cycle after `init`, `done` high on the 6th cycle, then IDLE.
- Backpressure:
  - stimulus: same sequence, `arb_ready` low for 3 cycles while entry 1 (ID 0) is presented;
  - response: `arbiter_input`=0 and valid held stable for those 3 cycles; order unchanged; no duplicated or skipped entries.
- Loop and restart:
  - stimulus: `seq_len`=3, `loop`=1, `arb_ready`=1, then a second `init` with `seq_len`=2 after 7 transfers;
  - response: pattern e0,e1,e2,e0,e1,e2,e0, then the new sequence starts at e0 on the cycle after the second `init`; `done` never asserts.
- Boundary lengths:
  - `seq_len`=0 gives `done` one cycle after `init` and `arbiter_valid` never high;
  - `seq_len`=`DEPTH`+5 issues exactly `DEPTH` IDs;
  - `enb`=0 for 4 cycles mid-run freezes the index.
- Histogram (macro defined):
  - stimulus: sequence {3,3,1,0}, `NUM_CH`=4;
  - response: after `done`, `hist_count` = {ch3:2, ch2:0, ch1:1, ch0:1}; a following `init` clears all counters to 0.

Source files
------------

// File: rtl/arb_seq_pkg.sv
// Shared types and helpers for the arbiter channel-request sequencer.
package arb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HIST_W = 16;
  localparam logic [HIST_W-1:0] HIST_MAX = '1;

  // LSB position of entry k in a flat bus of w-bit entries.
  function automatic int unsigned entry_lsb(input logic [31:0] k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/arb_seq_hist.sv
// Per-channel saturating counters of accepted channel IDs.
module arb_seq_hist
  import arb_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  input  logic [CH_W-1:0]          ch,
  output logic [NUM_CH*HIST_W-1:0] counts
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    logic [HIST_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst || clr)
        cnt <= '0;
      else if (inc && ch == CH_W'(c) && cnt != HIST_MAX)
        cnt <= cnt + HIST_W'(1);
    end
    assign counts[c*HIST_W +: HIST_W] = cnt;
  end

endmodule

// File: rtl/arbiter_seq_gen.sv
// Sequencer feeding the arbiter select port from a latched ID list.
// Define ARB_SEQ_HISTOGRAM_EN to build per-channel accepted-ID counters.
module arbiter_seq_gen
  import arb_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 64,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     init,
  input  logic [DEPTH*CH_W-1:0]    tester_input,
  input  logic [LEN_W-1:0]         seq_len,
  input  logic                     loop,
  input  logic                     arb_ready,
  output logic [CH_W-1:0]          arbiter_input,
  output logic                     arbiter_valid,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH*HIST_W-1:0] hist_count
);

  state_t                  state, state_n;
  logic [LEN_W-1:0]        idx, idx_n, len, len_n, len_sat, idx_nx;
  logic                    loop_q, loop_n;
  logic [DEPTH*CH_W-1:0]   shadow, shadow_n;
  logic [CH_W-1:0]         ain_n;
  logic                    avld_n, done_n, xfer;

  assign xfer    = arbiter_valid && arb_ready;
  assign len_sat = (seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : seq_len;
  assign idx_nx  = idx + LEN_W'(1);
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      len           <= '0;
      loop_q        <= 1'b0;
      shadow        <= '0;
      arbiter_input <= '0;
      arbiter_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      len           <= len_n;
      loop_q        <= loop_n;
      shadow        <= shadow_n;
      arbiter_input <= ain_n;
      arbiter_valid <= avld_n;
      done          <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    len_n    = len;
    loop_n   = loop_q;
    shadow_n = shadow;
    ain_n    = arbiter_input;
    avld_n   = arbiter_valid;
    done_n   = done;
    // With enb low nothing moves, including the done pulse.
    if (enb) begin
      done_n = 1'b0;
      if (init) begin
        shadow_n = tester_input;
        len_n    = len_sat;
        loop_n   = loop;
        idx_n    = '0;
        if (len_sat == '0) begin
          state_n = DONE;
          avld_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = RUN;
          avld_n  = 1'b1;
          ain_n   = tester_input[CH_W-1:0];
        end
      end else begin
        case (state)
          RUN: if (xfer) begin
            if (idx < len - LEN_W'(1)) begin
              idx_n = idx_nx;
              ain_n = shadow[entry_lsb(32'(idx_nx), CH_W) +: CH_W];
            end else if (loop_q) begin
              idx_n = '0;
              ain_n = shadow[CH_W-1:0];
            end else begin
              avld_n  = 1'b0;
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
          DONE:    state_n = IDLE;
          default: state_n = state;
        endcase
      end
    end
  end

`ifdef ARB_SEQ_HISTOGRAM_EN
  arb_seq_hist #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_hist (
    .clk    (clk),
    .rst    (rst),
    .clr    (enb && init),
    .inc    (enb && xfer),
    .ch     (arbiter_input),
    .counts (hist_count)
  );
`else
  assign hist_count = '0;
`endif

endmodule

// File: tb/tb_arbiter_seq_gen.sv
// Directed self-checking bench for arbiter_seq_gen (NUM_CH=4, DEPTH=8).
module tb_arbiter_seq_gen;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int CH_W   = 2;
  localparam int LEN_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst, enb, init, loop, arb_ready;
  logic [DEPTH*CH_W-1:0] tester_input;
  logic [LEN_W-1:0]      seq_len;
  logic [CH_W-1:0]       arbiter_input;
  logic                  arbiter_valid, busy, done;
  logic [NUM_CH*16-1:0]  hist_count;

  logic [DEPTH-1:0][CH_W-1:0] ev;
  int errors = 0;
  int checks = 0;

  arbiter_seq_gen #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .init          (init),
    .tester_input  (tester_input),
    .seq_len       (seq_len),
    .loop          (loop),
    .arb_ready     (arb_ready),
    .arbiter_input (arbiter_input),
    .arbiter_valid (arbiter_valid),
    .busy          (busy),
    .done          (done),
    .hist_count    (hist_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [CH_W-1:0] id);
    chk({tag, "_vld"}, 64'(arbiter_valid), 64'd1);
    chk({tag, "_id"}, 64'(arbiter_input), 64'(id));
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; init = 1'b0; loop = 1'b0; arb_ready = 1'b0;
    tester_input = '0; seq_len = '0;
    tick(); tick();
    chk("rst_vld", 64'(arbiter_valid), 64'd0);
    chk("rst_id", 64'(arbiter_input), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hist", hist_count, 64'd0);
    rst = 1'b0; enb = 1'b1;
    repeat (10) tick();
    chk("idle_vld", 64'(arbiter_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // Basic run: {2,0,1,2,1}
    ev = {2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2};
    tester_input = ev; seq_len = 4'd5; loop = 1'b0; arb_ready = 1'b1; init = 1'b1;
    tick(); init = 1'b0;
    chk("basic_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk_id("basic", ev[i]);
      chk("basic_nodone", 64'(done), 64'd0);
      tick();
    end
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_dvld", 64'(arbiter_valid), 64'd0);
    chk("basic_dbusy", 64'(busy), 64'd0);
    tick();
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_idle", 64'(busy), 64'd0);

    // Backpressure on entry 1
    init = 1'b1; tick(); init = 1'b0;
    chk_id("bp_e0", 2'd2);
    tick();
    chk_id("bp_e1", 2'd0);
    arb_ready = 1'b0;
    repeat (3) begin
      tick();
      chk_id("bp_hold", 2'd0);
    end
    arb_ready = 1'b1;
    tick(); chk_id("bp_e2", 2'd1);
    tick(); chk_id("bp_e3", 2'd2);
    tick(); chk_id("bp_e4", 2'd1);
    tick();
    chk("bp_done", 64'(done), 64'd1);
    tick();

    // Loop then restart
    ev = '0; ev[0] = 2'd1; ev[1] = 2'd3; ev[2] = 2'd2;
    tester_input = ev; seq_len = 4'd3; loop = 1'b1; init = 1'b1;
    tick(); init = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_id("loop", ev[i % 3]);
      chk("loop_nodone", 64'(done), 64'd0);
      tick();
    end
    chk_id("loop_e1", 2'd3);
    tester_input = {12'd0, 2'd2, 2'd0}; seq_len = 4'd2; loop = 1'b0; init = 1'b1;
    tick(); init = 1'b0;
    chk_id("restart_e0", 2'd0);
    chk("restart_nodone", 64'(done), 64'd0);
    tick(); chk_id("restart_e1", 2'd2);
    tick();
    chk("restart_done", 64'(done), 64'd1);
    tick();

    // Zero length
    seq_len = 4'd0; init = 1'b1;
    tick(); init = 1'b0;
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_vld", 64'(arbiter_valid), 64'd0);
    chk("len0_busy", 64'(busy), 64'd0);
    tick();
    chk("len0_done_off", 64'(done), 64'd0);
    chk("len0_vld2", 64'(arbiter_valid), 64'd0);

    // Oversized length saturates to DEPTH
    ev = {2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    tester_input = ev; seq_len = 4'(DEPTH + 5); init = 1'b1;
    tick(); init = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk_id("sat", ev[i]);
      tick();
    end
    chk("sat_done", 64'(done), 64'd1);
    chk("sat_vld", 64'(arbiter_valid), 64'd0);
    tick();

    // enb low freezes index and ignores init
    tester_input = {8'd0, 2'd0, 2'd3, 2'd2, 2'd1}; seq_len = 4'd4; init = 1'b1;
    tick(); init = 1'b0;
    chk_id("enb_e0", 2'd1);
    tick();
    chk_id("enb_e1", 2'd2);
    enb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      init = (i == 1);
      tick();
      chk_id("enb_frozen", 2'd2);
      chk("enb_busy", 64'(busy), 64'd1);
    end
    enb = 1'b1; init = 1'b0;
    tick(); chk_id("enb_e2", 2'd3);
    tick(); chk_id("enb_e3", 2'd0);
    tick();
    chk("enb_done", 64'(done), 64'd1);
    tick();

    // Histogram: {3,3,1,0}
    tester_input = {8'd0, 2'd0, 2'd1, 2'd3, 2'd3}; seq_len = 4'd4; init = 1'b1;
    tick(); init = 1'b0;
    repeat (4) tick();
    chk("hist_seq_done", 64'(done), 64'd1);
`ifdef ARB_SEQ_HISTOGRAM_EN
    chk("hist_counts", hist_count, {16'd2, 16'd0, 16'd1, 16'd1});
`else
    chk("hist_tied", hist_count, 64'd0);
`endif
    tick();
    init = 1'b1; tick(); init = 1'b0;
    chk("hist_clear", hist_count, 64'd0);

    // Reset mid-run
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_vld", 64'(arbiter_valid), 64'd0);
    chk("midrst_id", 64'(arbiter_input), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
